// File: rtl/tx_pkg.sv
// Shared transmit-path constants and types.
// Used by the TX FIFO and the TX encoder.
package tx_pkg;

    localparam int TX_DATA_W     = 8;
    localparam int TX_FIFO_DEPTH = 8;

    typedef logic [TX_DATA_W-1:0] tx_byte_t;

endpackage

// File: rtl/tx_fifo_ctrl.sv
// TX FIFO control: pointers, occupancy,
// accept decisions and sticky error flags.
module tx_fifo_ctrl
    import tx_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              w_enable,
    input  logic              r_enable,
    output logic              w_accept,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] rptr,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              underrun
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic r_accept;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop frees the slot being written when full.
    assign w_accept = !clear && w_enable && (!full || r_enable);
    assign r_accept = !clear && r_enable && !empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (w_accept) begin
                wptr <= wptr + 1'b1;
            end
            if (r_accept) begin
                rptr <= rptr + 1'b1;
            end
            if (w_accept && !r_accept) begin
                count <= count + 1'b1;
            end else if (r_accept && !w_accept) begin
                count <= count - 1'b1;
            end
            if (w_enable && full && !r_enable) begin
                overrun <= 1'b1;
            end
            if (r_enable && empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_fifo.sv
// Single-clock byte FIFO feeding the TX encoder.
// First-word-fall-through head, occupancy and error flags.
module tx_fifo
    import tx_pkg::*;
#(
    parameter int DATA_W = TX_DATA_W,
    parameter int DEPTH  = TX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              underrun
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              w_accept;

    tx_fifo_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .w_enable (w_enable),
        .r_enable (r_enable),
        .w_accept (w_accept),
        .wptr     (wptr),
        .rptr     (rptr),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overrun  (overrun),
        .underrun (underrun)
    );

    // Entries reset to zero so the idle head reads 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_accept) begin
            mem[wptr] <= w_data;
        end
    end

    assign r_data = mem[rptr];

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: queue model
// compared every cycle plus directed literal checks.
module tb_tx_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       w_enable;
    logic [7:0] w_data;
    logic       r_enable;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overrun;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 0;

    logic [7:0] q[$];
    bit m_ovr;
    bit m_und;

    tx_fifo dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .w_enable (w_enable),
        .w_data   (w_data),
        .r_enable (r_enable),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .underrun (underrun)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Reference model: an ordered queue of held bytes.
    always @(posedge clk or negedge n_rst) begin
        int sz;
        bit do_push;
        bit do_pop;
        if (!n_rst) begin
            q.delete();
            m_ovr = 0;
            m_und = 0;
        end else if (clear) begin
            q.delete();
            m_ovr = 0;
            m_und = 0;
        end else begin
            sz = q.size();
            do_push = w_enable && (sz < DEPTH || r_enable);
            do_pop  = r_enable && sz > 0;
            if (w_enable && sz == DEPTH && !r_enable) m_ovr = 1;
            if (r_enable && sz == 0) m_und = 1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(w_data);
        end
    end

    always @(negedge clk) begin
        if (n_rst && run) begin
            chk("m_count", 32'(count), q.size());
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
            chk("m_underrun", 32'(underrun), 32'(m_und));
            if (q.size() > 0)
                chk("m_rdata", 32'(r_data), 32'(q[0]));
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d,
                       input bit r, input bit c);
        w_enable = w;
        w_data   = d;
        r_enable = r;
        clear    = c;
        @(posedge clk);
        #1;
        w_enable = 0;
        r_enable = 0;
        clear    = 0;
    endtask

    task automatic fill_a0;
        for (int i = 0; i < 8; i++)
            cyc(1, 8'hA0 + 8'(i), 0, 0);
    endtask

    task automatic drain_a0(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk(tag, 32'(r_data), 32'(8'hA0 + 8'(i)));
            cyc(0, 8'h00, 1, 0);
        end
    endtask

    logic [7:0] wrap_exp [10];

    initial begin
        wrap_exp = '{8'h55, 8'h60, 8'h61, 8'h62, 8'h63,
                     8'h64, 8'h65, 8'h66, 8'h11, 8'h11};
        n_rst = 0;
        clear = 0;
        w_enable = 0;
        w_data = 0;
        r_enable = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdata", 32'(r_data), 0);
        @(negedge clk);
        #1 n_rst = 1;
        run = 1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a burst.
        cyc(1, 8'h31, 0, 0);
        cyc(1, 8'h32, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("pre_rst_count", 32'(count), 3);
        w_enable = 1;
        w_data = 8'h34;
        #2 n_rst = 0;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_rdata", 32'(r_data), 0);
        chk("arst_flags", 32'({overrun, underrun}), 0);
        @(negedge clk);
        #1;
        w_enable = 0;
        n_rst = 1;
        @(posedge clk);
        #1;

        // Fill and drain.
        fill_a0();
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 8);
        drain_a0("drain_order");
        chk("drain_empty", 32'(empty), 1);

        // Overrun: dropped push while full.
        fill_a0();
        cyc(1, 8'hFF, 0, 0);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_count", 32'(count), 8);
        drain_a0("ovr_order");

        // Underrun, then push+pop while empty.
        cyc(0, 8'h00, 1, 0);
        chk("und_flag", 32'(underrun), 1);
        chk("und_count", 32'(count), 0);
        cyc(1, 8'h55, 1, 0);
        chk("sim_count", 32'(count), 1);
        chk("sim_rdata", 32'(r_data), 32'h55);

        // Full with simultaneous push/pop across wrap.
        for (int i = 0; i < 7; i++)
            cyc(1, 8'h60 + 8'(i), 0, 0);
        chk("wrap_start", 32'(count), 8);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_head", 32'(r_data), 32'(wrap_exp[i]));
            cyc(1, 8'h11, 1, 0);
            chk("wrap_count", 32'(count), 8);
        end

        // Clear beats a same-cycle push.
        cyc(0, 8'h00, 0, 1);
        fill_a0();
        cyc(1, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 8'h00, 1, 0);
        chk("clr_pre_count", 32'(count), 5);
        chk("clr_pre_ovr", 32'(overrun), 1);
        cyc(1, 8'hEE, 0, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_ovr", 32'(overrun), 0);
        cyc(1, 8'h77, 0, 0);
        chk("clr_next", 32'(r_data), 32'h77);
        chk("clr_next_cnt", 32'(count), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
